// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, load/store data port and the byte-wide memory pins.
// The arbiter is the master; the fetch unit, LSB and memory together form the slave side.
interface mem_bus_arbiter_if;
  logic        i_waiting;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_result;

  logic        d_waiting;
  logic        d_wr;
  logic [2:0]  d_len;
  logic [31:0] d_addr;
  logic [31:0] d_value;
  logic        d_ready;
  logic [31:0] d_result;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport master (
    input  i_waiting, i_addr, d_waiting, d_wr, d_len, d_addr, d_value, mem_din,
    output i_ready, i_result, d_ready, d_result, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output i_waiting, i_addr, d_waiting, d_wr, d_len, d_addr, d_value, mem_din,
    input  i_ready, i_result, d_ready, d_result, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the byte-wide memory bus between instruction fetch and the load/store buffer,
// serialising multi-byte accesses and reassembling read data little-endian.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic clear,
  input  logic io_buffer_full,
  output logic busy,
  mem_bus_arbiter_if.master bus
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic        owner_d, owner_d_nx;
  logic [31:0] base, base_nx;
  logic [2:0]  len, len_nx;
  logic        wr, wr_nx;
  logic [31:0] value, value_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [SW-1:0] starve, starve_nx;
  logic [31:0] rbuf, rbuf_nx;
  logic [31:0] i_res_q, i_res_nx;
  logic [31:0] d_res_q, d_res_nx;

  logic        io_stall;
  logic        last_write;
  logic        grant_fetch;
  logic [1:0]  cap_idx;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        i_ready;
  logic        d_ready;
  logic        d_read_done;

  assign io_stall    = (base[17:16] == 2'b11) && io_buffer_full;
  assign last_write  = ({1'b0, cnt} + 4'd1) >= {1'b0, len};
  assign grant_fetch = bus.i_waiting && ((starve == STARVE_MAX) || !bus.d_waiting);
  // Read data arrives one cycle behind its address, so the byte captured now belongs to cnt-1.
  assign cap_idx     = 2'(cnt - 3'd1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      base    <= '0;
      len     <= '0;
      wr      <= 1'b0;
      value   <= '0;
      cnt     <= '0;
      starve  <= '0;
      rbuf    <= '0;
      i_res_q <= '0;
      d_res_q <= '0;
    end else if (rdy_in) begin
      state   <= state_nx;
      owner_d <= owner_d_nx;
      base    <= base_nx;
      len     <= len_nx;
      wr      <= wr_nx;
      value   <= value_nx;
      cnt     <= cnt_nx;
      starve  <= starve_nx;
      rbuf    <= rbuf_nx;
      i_res_q <= i_res_nx;
      d_res_q <= d_res_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_d_nx  = owner_d;
    base_nx     = base;
    len_nx      = len;
    wr_nx       = wr;
    value_nx    = value;
    cnt_nx      = cnt;
    starve_nx   = starve;
    rbuf_nx     = rbuf;
    i_res_nx    = i_res_q;
    d_res_nx    = d_res_q;
    mem_a       = '0;
    mem_dout    = '0;
    mem_wr      = 1'b0;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    d_read_done = 1'b0;

    case (state)
      IDLE: begin
        if (!clear) begin
          if (grant_fetch) begin
            owner_d_nx = 1'b0;
            base_nx    = bus.i_addr;
            len_nx     = 3'd4;
            wr_nx      = 1'b0;
            value_nx   = '0;
            cnt_nx     = '0;
            rbuf_nx    = '0;
            starve_nx  = '0;
            state_nx   = READ;
          end else if (bus.d_waiting) begin
            owner_d_nx = 1'b1;
            base_nx    = bus.d_addr;
            len_nx     = bus.d_len;
            wr_nx      = bus.d_wr;
            value_nx   = bus.d_value;
            cnt_nx     = '0;
            rbuf_nx    = '0;
            if (bus.i_waiting) starve_nx = starve + SW'(1);
            state_nx   = bus.d_wr ? WRITE : READ;
          end
        end
      end

      READ: begin
        // While paused, present the address whose byte is captured first on resume.
        if (!rdy_in)
          mem_a = (cnt == 3'd0) ? base : base + 32'(cnt) - 32'd1;
        else if (cnt < len)
          mem_a = base + 32'(cnt);
        if (clear) begin
          state_nx = IDLE;
        end else begin
          if (cnt != 3'd0) rbuf_nx[{cap_idx, 3'b000} +: 8] = bus.mem_din;
          if (cnt >= len) state_nx = DONE;
          else            cnt_nx   = cnt + 3'd1;
        end
      end

      WRITE: begin
        mem_a    = base + 32'(cnt);
        mem_dout = value[{cnt[1:0], 3'b000} +: 8];
        mem_wr   = rdy_in && !io_stall;
        if (!io_stall) begin
          if (last_write) state_nx = DONE;
          else            cnt_nx   = cnt + 3'd1;
        end
      end

      DONE: begin
        state_nx = IDLE;
        // Committed writes always report completion; a flush only drops read results.
        if (owner_d) begin
          if (wr) begin
            d_ready = rdy_in;
          end else if (!clear) begin
            d_ready     = rdy_in;
            d_read_done = rdy_in;
            d_res_nx    = rbuf;
          end
        end else if (!clear) begin
          i_ready  = rdy_in;
          i_res_nx = rbuf;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign bus.mem_a    = mem_a;
  assign bus.mem_dout = mem_dout;
  assign bus.mem_wr   = mem_wr;
  assign bus.i_ready  = i_ready;
  assign bus.i_result = i_ready ? rbuf : i_res_q;
  assign bus.d_ready  = d_ready;
  assign bus.d_result = d_read_done ? rbuf : d_res_q;

endmodule
